uart_rx_fifo_controller: RTL and testbench

//  Parametrised UART receiver with a show-ahead receive FIFO, sticky error flags and optional parity.

---
 rtl/uart_rx_fifo_controller.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_fifo_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_controller.sv
// UART receiver with a show-ahead receive FIFO and sticky error flags.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo_controller #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                          Clock_50,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          Unload_data,
  input  logic                          Clear_errors,
  output logic [DATA_BITS-1:0]          RX_data,
  output logic                          Empty,
  output logic                          Full,
  output logic [$clog2(FIFO_DEPTH):0]   Fill_level,
  output logic                          Overrun,
  output logic                          Frame_error,
  output logic                          Parity_error,
  input  logic                          UART_RX_I
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [PtrW:0]   DepthLvl = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StSync, StData, StParity, StStop} state_t;

  logic                 r_rx_meta, r_rx_s;
  state_t               r_state, w_state_d;
  logic [CntW-1:0]      r_clk_cnt, w_clk_cnt_d;
  logic [BitW-1:0]      r_bit_cnt, w_bit_cnt_d;
  logic [DATA_BITS-1:0] r_shift, w_shift_d;
  logic                 r_par_bad, w_par_bad_d;
  logic                 w_bit_tick, w_stop_smp;
  logic                 w_push, w_pop, w_push_ok, w_overrun, w_frame_bad;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]        r_count;
  logic                 r_overrun, r_frame_err;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= UART_RX_I;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_bit_tick = (r_clk_cnt == BitLast);

  // Receive FSM next-state, bit timing and shift register.
  always_comb begin
    w_state_d   = r_state;
    w_clk_cnt_d = r_clk_cnt + 1'b1;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_par_bad_d = r_par_bad;
    w_stop_smp  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_clk_cnt_d = '0;
        w_par_bad_d = 1'b0;
        if (Enable && !r_rx_s) begin
          w_state_d   = StSync;
          w_bit_cnt_d = '0;
        end
      end
      StSync: begin
        // A high line before mid start bit is a glitch: drop silently.
        if (r_rx_s) begin
          w_state_d   = StIdle;
          w_clk_cnt_d = '0;
        end else if (r_clk_cnt == HalfLast) begin
          w_state_d   = StData;
          w_clk_cnt_d = '0;
        end
      end
      StData: begin
        if (w_bit_tick) begin
          w_clk_cnt_d = '0;
          w_shift_d   = {r_rx_s, r_shift[DATA_BITS-1:1]};
          w_bit_cnt_d = r_bit_cnt + 1'b1;
          if (r_bit_cnt == DataLast) begin
`ifdef UART_RX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (w_bit_tick) begin
          w_clk_cnt_d = '0;
          w_par_bad_d = ((^r_shift) ^ r_rx_s) != PARITY_ODD[0];
          w_state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (w_bit_tick) begin
          w_clk_cnt_d = '0;
          w_stop_smp  = 1'b1;
          w_state_d   = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Receive FSM state register.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      r_state   <= StIdle;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_clk_cnt <= w_clk_cnt_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
      r_par_bad <= w_par_bad_d;
    end
  end

  assign w_frame_bad = w_stop_smp && !r_rx_s;
  assign w_push      = w_stop_smp && r_rx_s && !r_par_bad;
  assign w_pop       = Unload_data && !Empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign w_push_ok   = w_push && (!Full || w_pop);
  assign w_overrun   = w_push && Full && !w_pop;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign RX_data    = r_mem[r_rd_ptr];
  assign Empty      = (r_count == '0);
  assign Full       = (r_count == DepthLvl);
  assign Fill_level = r_count;

  // Sticky error flags; a new error outranks a same-cycle clear.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_overrun)         r_overrun <= 1'b1;
      else if (Clear_errors) r_overrun <= 1'b0;
      if (w_frame_bad)       r_frame_err <= 1'b1;
      else if (Clear_errors) r_frame_err <= 1'b0;
    end
  end

  assign Overrun     = r_overrun;
  assign Frame_error = r_frame_err;

`ifdef UART_RX_PARITY_EN
  logic r_parity_err;
  logic w_par_fail;
  assign w_par_fail = w_stop_smp && r_rx_s && r_par_bad;

  // Sticky parity flag.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset)             r_parity_err <= 1'b0;
    else if (w_par_fail)   r_parity_err <= 1'b1;
    else if (Clear_errors) r_parity_err <= 1'b0;
  end
  assign Parity_error = r_parity_err;
`else
  assign Parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_controller.sv
// Self-checking bench for uart_rx_fifo_controller: directed cases then randomized frames,
// all checked against a queue-based model of the receive FIFO and error flags.
module tb_uart_rx_fifo_controller;
  localparam int unsigned CPB   = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PODD  = 0;

  logic          clk = 1'b0;
  logic          rst, en, unload, clr, rx;
  logic [DW-1:0] rx_data;
  logic          empty, full, ovr, ferr, perr;
  logic [2:0]    fill;

  always #5 clk = ~clk;

  uart_rx_fifo_controller #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DW),
    .FIFO_DEPTH  (DEPTH),
    .PARITY_ODD  (PODD)
  ) u_dut (
    .Clock_50    (clk),
    .Reset       (rst),
    .Enable      (en),
    .Unload_data (unload),
    .Clear_errors(clr),
    .RX_data     (rx_data),
    .Empty       (empty),
    .Full        (full),
    .Fill_level  (fill),
    .Overrun     (ovr),
    .Frame_error (ferr),
    .Parity_error(perr),
    .UART_RX_I   (rx)
  );

  int n_checks = 0;
  int n_pass   = 0;

  byte unsigned q[$];
  bit m_ovr, m_ferr, m_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    check({tag, ":fill"},  32'(fill),  32'(q.size()));
    check({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ":full"},  32'(full),  32'(q.size() == DEPTH));
    check({tag, ":ovr"},   32'(ovr),   32'(m_ovr));
    check({tag, ":ferr"},  32'(ferr),  32'(m_ferr));
    check({tag, ":perr"},  32'(perr),  32'(m_perr));
    if (q.size() > 0) check({tag, ":data"}, 32'(rx_data), 32'(q[0]));
  endtask

  // One UART frame, bit time CPB. Optional pop/clear pulses land on the stop-sample cycle,
  // which falls 11 clocks into the stop bit (2-flop sync + half-bit alignment).
  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit par_flip,
                            input bit pop_s, input bit clr_s, input bit chk_lat);
    logic [11:0] fr;
    int          nb;
    bit          was_en;
    bit          pbad;
    was_en = en;
    fr     = '1;
    fr[0]  = 1'b0;
    fr[8:1] = d;
`ifdef UART_RX_PARITY_EN
    fr[9]  = (^d) ^ PODD[0] ^ par_flip;
    fr[10] = stop_b;
    nb     = 11;
    pbad   = par_flip;
`else
    fr[9]  = stop_b;
    nb     = 10;
    pbad   = 1'b0;
`endif
    @(posedge clk);
    for (int i = 0; i < nb - 1; i++) begin
      #1 rx = fr[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop_b;
    repeat (10) @(posedge clk);
    #1;
    if (chk_lat) check("lat_before", 32'(empty), 32'(q.size() == 0));
    unload = pop_s;
    clr    = clr_s;
    @(posedge clk);
    #1 unload = 1'b0;
    clr = 1'b0;
    if (clr_s) begin
      m_ovr = 0; m_ferr = 0; m_perr = 0;
    end
    if (pop_s && q.size() > 0) void'(q.pop_front());
    if (was_en) begin
      if (!stop_b)                m_ferr = 1;
      else if (pbad)              m_perr = 1;
      else if (q.size() < DEPTH)  q.push_back(d);
      else                        m_ovr = 1;
    end
    if (chk_lat) check("lat_after", 32'(empty), 32'(q.size() == 0));
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic pop_one();
    @(posedge clk);
    #1 unload = 1'b1;
    @(posedge clk);
    #1 unload = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clear_pulse();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    m_ovr = 0; m_ferr = 0; m_perr = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; unload = 1'b0; clr = 1'b0; rx = 1'b1;
    m_ovr = 0; m_ferr = 0; m_perr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:data", 32'(rx_data), 32'h0);
    check_model("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Single frame, exact visibility latency, then unload.
    send_frame(8'hA5, 1, 0, 0, 0, 1);
    check_model("t1");
    check("t1:byte", 32'(rx_data), 32'hA5);
    pop_one();
    check_model("t1_pop");

    // Overflow: fifth frame dropped, order preserved.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 0, 0, 0, 0);
    check_model("t2_full");
    for (int i = 1; i <= 4; i++) begin
      check("t2_order", 32'(rx_data), 32'(i));
      pop_one();
      check_model("t2_drain");
    end
    clear_pulse();
    check_model("t2_clr");

    // Framing error, then clear.
    send_frame(8'h3C, 0, 0, 0, 0, 0);
    check_model("t3");
    clear_pulse();
    check_model("t3_clr");

    // Short low glitch is rejected; the next frame is still received.
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    check_model("t4_glitch");
    send_frame(8'h5A, 1, 0, 0, 0, 0);
    check_model("t4_after");
    pop_one();

    // Enable low: frames are ignored.
    en = 1'b0;
    send_frame(8'hEE, 1, 0, 0, 0, 0);
    check_model("en_off");
    en = 1'b1;

    // Full FIFO with pop on the push cycle: no overrun, new byte at tail.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1, 0, 0, 0, 0);
    send_frame(8'h99, 1, 0, 1, 0, 0);
    check_model("t5");
    for (int i = 0; i < 4; i++) begin
      pop_one();
      check_model("t5_drain");
    end

    // Clear on the error cycle: the set wins.
    send_frame(8'h44, 0, 0, 0, 1, 0);
    check_model("clr_vs_set");
    clear_pulse();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1, 1, 0, 0, 0);
    check_model("t6_bad");
    send_frame(8'h07, 1, 0, 0, 0, 0);
    check_model("t6_good");
    clear_pulse();
    pop_one();
`endif

    // Reset mid-DATA with two entries stored.
    send_frame(8'h21, 1, 0, 0, 0, 0);
    send_frame(8'h22, 1, 0, 0, 0, 0);
    check_model("t7_pre");
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1 rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    m_ovr = 0; m_ferr = 0; m_perr = 0;
    check_model("t7_rst");
    check("t7:data", 32'(rx_data), 32'h0);
    repeat (5) @(posedge clk);
    send_frame(8'hC3, 1, 0, 0, 0, 0);
    check_model("t7_next");

    // Randomized frames, unloads and clears.
    for (int it = 0; it < 40; it++) begin
      int npop;
      npop = int'($urandom_range(2));
      for (int k = 0; k < npop; k++) pop_one();
      if ($urandom_range(7) == 0) clear_pulse();
      send_frame(8'($urandom), $urandom_range(9) != 0, $urandom_range(7) == 0,
                 $urandom_range(3) == 0, $urandom_range(5) == 0, 0);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
